// File: rtl/serial_slave_bridge_pkg.sv
// Shared types for the serial slave bridge: the FSM state encoding and a helper
// that gives the width of a local request word.
package serial_slave_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WRITE,
    S_RD_REQ,
    S_READ,
    S_SPLIT,
    S_SEND
  } state_t;

  function automatic int req_width(input int addr_width, input int data_width);
    return 1 + addr_width + data_width;
  endfunction

endpackage

// File: rtl/serial_slave_bridge_fifo.sv
// Show-ahead synchronous request queue. o_head is the oldest entry and is forced
// to zero while the queue is empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/serial_slave_bridge.sv
// Bit-serial slave: shifts in address/data frames from a serial master, queues
// {mode, addr, data} requests to the local side and serialises read responses back.
module serial_slave_bridge
  import serial_slave_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int SPLIT_EN      = 0,
  parameter int SPLIT_TIMEOUT = 8
) (
  input  logic                                        clk,
  input  logic                                        rstn,
  input  logic                                        mode,
  input  logic                                        wr_bus,
  input  logic                                        master_valid,
  input  logic                                        master_ready,
  output logic                                        rd_bus,
  output logic                                        slave_ready,
  output logic                                        slave_valid,
  output logic                                        split,
  output logic [req_width(ADDR_WIDTH,DATA_WIDTH)-1:0] req_data,
  output logic                                        req_valid,
  input  logic                                        req_ready,
  input  logic                                        rsp_valid,
  input  logic [DATA_WIDTH-1:0]                       rsp_data,
  output logic [$clog2(FIFO_DEPTH):0]                 fifo_count,
  output state_t                                      dbg_state
);

  localparam int RW = req_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int CW = $clog2(ADDR_WIDTH + DATA_WIDTH + 1);
  localparam int WW = $clog2(SPLIT_TIMEOUT + 1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SPLIT_TIMEOUT - 1);

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [WW-1:0]         r_wait, w_wait_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic [DATA_WIDTH-1:0] r_rsp, w_rsp_nxt;
  logic [DATA_WIDTH-1:0] w_rsp_shift;
  logic                  w_push;
  logic [RW-1:0]         w_push_data;
  logic                  w_empty;
  logic                  w_full;

  // Shifting left by the bit counter puts the current MSB-first bit on top.
  assign w_rsp_shift = r_rsp << r_cnt;
  assign req_valid   = !w_empty;
  assign dbg_state   = r_state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wait  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_rsp   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wait  <= w_wait_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_rsp   <= w_rsp_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wait_nxt  = r_wait;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_rsp_nxt   = r_rsp;
    w_push      = 1'b0;
    w_push_data = '0;
    slave_ready = 1'b0;
    slave_valid = 1'b0;
    split       = 1'b0;
    rd_bus      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (master_valid && !w_full) begin
          w_state_nxt = S_ADDR;
          w_cnt_nxt   = '0;
        end
      end
      S_ADDR: begin
        slave_ready = 1'b1;
        if (!master_valid) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_addr_nxt = {r_addr[ADDR_WIDTH-2:0], wr_bus};
          w_cnt_nxt  = r_cnt + CW'(1);
          if (r_cnt == ADDR_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = mode ? S_DATA : S_RD_REQ;
          end
        end
      end
      S_DATA: begin
        slave_ready = 1'b1;
        if (!master_valid) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_data_nxt = {r_data[DATA_WIDTH-2:0], wr_bus};
          w_cnt_nxt  = r_cnt + CW'(1);
          if (r_cnt == DATA_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        w_push      = 1'b1;
        w_push_data = {1'b1, r_addr, r_data};
        w_state_nxt = S_IDLE;
      end
      S_RD_REQ: begin
        w_push      = 1'b1;
        w_push_data = {1'b0, r_addr, {DATA_WIDTH{1'b0}}};
        w_state_nxt = S_READ;
        w_cnt_nxt   = '0;
        w_wait_nxt  = '0;
      end
      S_READ: begin
        if (rsp_valid) begin
          w_rsp_nxt   = rsp_data;
          w_state_nxt = S_SEND;
          w_cnt_nxt   = '0;
        end else if (SPLIT_EN != 0) begin
          if (r_wait == WAIT_LAST) begin
            w_state_nxt = S_SPLIT;
            w_cnt_nxt   = '0;
          end else begin
            w_wait_nxt = r_wait + WW'(1);
          end
        end
      end
      S_SPLIT: begin
        split = 1'b1;
        if (rsp_valid) begin
          w_rsp_nxt   = rsp_data;
          w_state_nxt = S_SEND;
          w_cnt_nxt   = '0;
        end
      end
      S_SEND: begin
        slave_valid = 1'b1;
        rd_bus      = w_rsp_shift[DATA_WIDTH-1];
        if (master_ready) begin
          if (r_cnt == DATA_LAST) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (req_valid && req_ready),
    .o_head  (req_data),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (fifo_count)
  );

endmodule

// File: tb/tb_serial_slave_bridge.sv
// Directed bench for serial_slave_bridge: one split-capable instance and one
// without split, driven by the same serial master and local-side stimulus.
module tb_serial_slave_bridge;
  import serial_slave_bridge_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int RW = 25;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic mode = 1'b0;
  logic wr_bus = 1'b0;
  logic master_valid = 1'b0;
  logic master_ready = 1'b0;
  logic req_ready = 1'b0;
  logic rsp_valid = 1'b0;
  logic [DW-1:0] rsp_data = '0;

  logic          rd_bus, slave_ready, slave_valid, split, req_valid;
  logic [RW-1:0] req_data;
  logic [2:0]    fifo_count;
  state_t        dbg_state;

  logic          rd_bus_n, slave_ready_n, slave_valid_n, split_n, req_valid_n;
  logic [RW-1:0] req_data_n;
  logic [2:0]    fifo_count_n;
  state_t        dbg_state_n;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] sb_exp;

  serial_slave_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .SPLIT_EN(1), .SPLIT_TIMEOUT(8)
  ) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .wr_bus(wr_bus),
    .master_valid(master_valid), .master_ready(master_ready),
    .rd_bus(rd_bus), .slave_ready(slave_ready), .slave_valid(slave_valid), .split(split),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .fifo_count(fifo_count),
    .dbg_state(dbg_state)
  );

  serial_slave_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .SPLIT_EN(0), .SPLIT_TIMEOUT(8)
  ) dut_nosplit (
    .clk(clk), .rstn(rstn), .mode(mode), .wr_bus(wr_bus),
    .master_valid(master_valid), .master_ready(master_ready),
    .rd_bus(rd_bus_n), .slave_ready(slave_ready_n), .slave_valid(slave_valid_n), .split(split_n),
    .req_data(req_data_n), .req_valid(req_valid_n), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .fifo_count(fifo_count_n),
    .dbg_state(dbg_state_n)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive_addr(input logic m, input logic [AW-1:0] a);
    int n;
    n = 0;
    mode = m;
    master_valid = 1'b1;
    while (slave_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("frame_accept", slave_ready, 1);
    for (int i = AW-1; i >= 0; i--) begin
      wr_bus = a[i];
      tick();
    end
  endtask

  task automatic write_frame(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive_addr(1'b1, a);
    for (int i = DW-1; i >= 0; i--) begin
      wr_bus = d[i];
      tick();
    end
    master_valid = 1'b0;
    wr_bus = 1'b0;
    chk("write_state", dbg_state, S_WRITE);
    exp_q.push_back({1'b1, a, d});
    tick();
    chk("write_back_idle", dbg_state, S_IDLE);
  endtask

  task automatic read_req(input logic [AW-1:0] a);
    drive_addr(1'b0, a);
    master_valid = 1'b0;
    wr_bus = 1'b0;
    chk("rd_req_state", dbg_state, S_RD_REQ);
    exp_q.push_back({1'b0, a, 8'h00});
    tick();
    chk("read_state", dbg_state, S_READ);
  endtask

  task automatic drain_send(input logic [DW-1:0] bits);
    master_ready = 1'b1;
    for (int i = 0; i < DW; i++) begin
      chk("send_valid", slave_valid, 1);
      chk("send_bit", rd_bus, bits[DW-1-i]);
      tick();
    end
    master_ready = 1'b0;
    chk("send_done_idle", dbg_state, S_IDLE);
    chk("send_done_valid", slave_valid, 0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (req_valid === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_fifo_count", fifo_count, 0);
  endtask

  // Scoreboard: every local handshake must deliver the oldest expected request
  always @(negedge clk) begin
    if (rstn && req_valid && req_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected obs=%0h exp=none", req_data);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("sb_req_data", req_data, sb_exp);
      end
    end
  end

  initial begin
    logic [DW-1:0] bits;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_slave_ready", slave_ready, 0);
    chk("rst_slave_valid", slave_valid, 0);
    chk("rst_split", split, 0);
    chk("rst_rd_bus", rd_bus, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_data", req_data, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_state", dbg_state, S_IDLE);
    rstn = 1'b1;
    req_ready = 1'b1;
    tick();

    // Write frame 0x1234 / 0xA5
    write_frame(16'h1234, 8'hA5);
    chk("wr_req_valid", req_valid, 1);
    chk("wr_req_data", req_data, 25'h11234A5);
    chk("wr_fifo_count", fifo_count, 1);
    tick();
    chk("wr_req_valid_pulse_end", req_valid, 0);
    chk("wr_fifo_empty", fifo_count, 0);

    // Read 0x00F0, response 0x3C three cycles after RD_REQ
    read_req(16'h00F0);
    tick();
    tick();
    chk("rd_waiting", dbg_state, S_READ);
    rsp_valid = 1'b1;
    rsp_data = 8'h3C;
    tick();
    rsp_valid = 1'b0;
    chk("rd_send_state", dbg_state, S_SEND);
    chk("rd_no_split", split, 0);
    bits = 8'b00111100;
    drain_send(bits);

    // Split after 8 READ cycles, response 20 cycles into the wait
    read_req(16'h0ABC);
    for (int i = 0; i < 8; i++) begin
      chk("sp_split_low", split, 0);
      chk("sp_in_read", dbg_state, S_READ);
      tick();
    end
    chk("sp_split_high", split, 1);
    chk("sp_state", dbg_state, S_SPLIT);
    chk("sp_nosplit_split", split_n, 0);
    chk("sp_nosplit_state", dbg_state_n, S_READ);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("sp_split_hold", split, 1);
      chk("sp_nosplit_hold", dbg_state_n, S_READ);
    end
    rsp_valid = 1'b1;
    rsp_data = 8'h96;
    tick();
    rsp_valid = 1'b0;
    chk("sp_send_state", dbg_state, S_SEND);
    chk("sp_split_drop", split, 0);
    chk("sp_nosplit_send", dbg_state_n, S_SEND);
    chk("sp_nosplit_valid", slave_valid_n, 1);
    chk("sp_nosplit_bit0", rd_bus_n, 1);
    chk("sp_nosplit_ready", slave_ready_n, 0);
    bits = 8'h96;
    drain_send(bits);
    chk("sp_nosplit_req_valid", req_valid_n, 0);
    chk("sp_nosplit_req_data", req_data_n, 0);
    chk("sp_nosplit_count", fifo_count_n, 0);

    // master_ready toggling in SEND: 16 cycles for 8 bits
    read_req(16'h5555);
    rsp_valid = 1'b1;
    rsp_data = 8'hC3;
    tick();
    rsp_valid = 1'b0;
    bits = 8'hC3;
    for (int k = 0; k < 16; k++) begin
      master_ready = (k % 2 == 1);
      chk("tg_valid", slave_valid, 1);
      chk("tg_bit", rd_bus, bits[DW-1-(k/2)]);
      tick();
    end
    master_ready = 1'b0;
    chk("tg_idle", dbg_state, S_IDLE);
    chk("tg_valid_low", slave_valid, 0);

    // Reset pulse in the middle of SEND
    read_req(16'h0F0F);
    rsp_valid = 1'b1;
    rsp_data = 8'hFF;
    tick();
    rsp_valid = 1'b0;
    master_ready = 1'b1;
    tick();
    tick();
    chk("mr_sending", slave_valid, 1);
    chk("mr_bit", rd_bus, 1);
    rstn = 1'b0;
    #1;
    chk("mr_rd_bus", rd_bus, 0);
    chk("mr_slave_valid", slave_valid, 0);
    chk("mr_slave_ready", slave_ready, 0);
    chk("mr_split", split, 0);
    chk("mr_req_valid", req_valid, 0);
    chk("mr_req_data", req_data, 0);
    chk("mr_fifo_count", fifo_count, 0);
    chk("mr_state", dbg_state, S_IDLE);
    master_ready = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    chk("mr_after_idle", dbg_state, S_IDLE);
    chk("mr_after_valid", slave_valid, 0);

    // Full queue blocks a new frame, then drains in order
    req_ready = 1'b0;
    write_frame(16'h1001, 8'h11);
    write_frame(16'h2002, 8'h22);
    write_frame(16'h3003, 8'h33);
    write_frame(16'h4004, 8'h44);
    chk("full_count", fifo_count, 4);
    chk("full_head", req_data, 25'h11001_11);
    mode = 1'b1;
    master_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_held_ready", slave_ready, 0);
      chk("full_held_idle", dbg_state, S_IDLE);
    end
    req_ready = 1'b1;
    write_frame(16'h5005, 8'h55);
    wait_drain();

    // Aborted frame after 5 address bits
    req_ready = 1'b0;
    write_frame(16'h6006, 8'h66);
    chk("ab_count_before", fifo_count, 1);
    mode = 1'b1;
    master_valid = 1'b1;
    tick();
    chk("ab_accept", slave_ready, 1);
    bits = 8'b10110000;
    for (int i = 0; i < 5; i++) begin
      wr_bus = bits[DW-1-i];
      tick();
    end
    master_valid = 1'b0;
    wr_bus = 1'b0;
    tick();
    chk("ab_idle", dbg_state, S_IDLE);
    chk("ab_count_same", fifo_count, 1);
    chk("ab_ready_low", slave_ready, 0);
    write_frame(16'hBEEF, 8'h5A);
    chk("ab_count_after", fifo_count, 2);
    req_ready = 1'b1;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_slave_bridge.md
SERIAL_SLAVE_BRIDGE -- requirements
Module: serial_slave_bridge

Interface
REQ-001 The block SHALL take parameter ADDR_WIDTH, default 16, the serial address length in bits.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 8, the serial data length in bits.
REQ-003 The block SHALL take parameter FIFO_DEPTH, default 4 (power of 2, >=2), the depth of the local request queue.
REQ-004 The block SHALL take parameter SPLIT_EN, default 0: 1 = read-split capability enabled.
REQ-005 The block SHALL take parameter SPLIT_TIMEOUT, default 8, the READ-wait cycles before a split.
REQ-006 The block SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-007 The block SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have ports mode (1=write, 0=read), wr_bus (serial master data), master_valid and master_ready, each an input of 1 bit.
REQ-009 The block SHALL have ports rd_bus (serial read data), slave_ready, slave_valid and split, each an output of 1 bit.
REQ-010 The block SHALL have port req_data, output, 1+ADDR_WIDTH+DATA_WIDTH bits: {mode, addr, data} presented to the local side.
REQ-011 The block SHALL have ports req_valid (output, 1 bit) and req_ready (input, 1 bit) forming the local request handshake.
REQ-012 The block SHALL have ports rsp_valid (input, 1 bit) and rsp_data (input, DATA_WIDTH bits) carrying the local read response.
REQ-013 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: the number of queued requests.

Function
REQ-014 The FSM SHALL implement states IDLE, ADDR, DATA, WRITE, RD_REQ, READ, SPLIT and SEND.
REQ-015 IDLE SHALL go to ADDR when master_valid=1 and the FIFO is not full; otherwise it SHALL stay in IDLE.
REQ-016 slave_ready SHALL be 1 exactly in ADDR and DATA.
REQ-017 In ADDR and DATA, each cycle with master_valid=1 SHALL shift one wr_bus bit MSB-first and increment the bit counter.
REQ-018 master_valid=0 in ADDR or DATA SHALL abort the frame to IDLE with nothing pushed and the counter cleared.
REQ-019 After ADDR_WIDTH address bits, the block SHALL sample mode and go to DATA if mode=1, else to RD_REQ.
REQ-020 After DATA_WIDTH data bits, the block SHALL go to WRITE.
REQ-021 WRITE SHALL push {1, addr, data} for one cycle and then go to IDLE.
REQ-022 RD_REQ SHALL push {0, addr, 0} for one cycle and then go to READ.
REQ-023 READ and SPLIT SHALL capture rsp_data on rsp_valid=1 and go to SEND in the next cycle.
REQ-024 In READ with SPLIT_EN=1, the wait-cycle count reaching SPLIT_TIMEOUT without rsp_valid SHALL move the FSM to SPLIT.
REQ-025 With SPLIT_EN=0, READ SHALL wait indefinitely.
REQ-026 split SHALL be 1 exactly in SPLIT.
REQ-027 slave_valid SHALL be 1 exactly in SEND.
REQ-028 In SEND, rd_bus SHALL be the captured response bit at the counter position, MSB first.
REQ-029 In SEND, the bit counter SHALL advance only on cycles with master_ready=1.
REQ-030 After DATA_WIDTH acknowledged bits, SEND SHALL go to IDLE.
REQ-031 rd_bus SHALL be 0 outside SEND.
REQ-032 The FIFO SHALL be show-ahead: req_valid=!empty, and req_data SHALL be the head entry.
REQ-033 The FIFO SHALL pop on req_valid&&req_ready.
REQ-034 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-035 A push into an empty FIFO SHALL raise req_valid on the following cycle.
REQ-036 Write and read requests SHALL leave the FIFO in arrival order.
REQ-037 The full check in IDLE SHALL guarantee that no push ever occurs while the FIFO is full; the FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-038 The bit counter SHALL be $clog2(ADDR_WIDTH+DATA_WIDTH+1) bits wide and SHALL be cleared on each state entry from IDLE, READ and SPLIT.

Reset
REQ-039 rstn=0 SHALL put the FSM in IDLE.
REQ-040 rstn=0 SHALL clear the counters, the FIFO pointers and fifo_count, and the addr, data and response registers.
REQ-041 While rstn=0, all outputs SHALL be 0.
REQ-042 Assertion of rstn mid-frame SHALL discard the partial frame and any pending read.

Structure
REQ-043 A shared package SHALL hold the state enum type and a function returning the request width 1+ADDR_WIDTH+DATA_WIDTH.
REQ-044 The request queue SHALL be the sub-module sync_fifo, parametrised by WIDTH and DEPTH.

Verification
REQ-045 Bench SHALL cover: write frame addr=0x1234, data=0xA5, req_ready=1 -> one req_data=0x1_1234_A5, req_valid pulse, FSM back in IDLE.
REQ-046 Bench SHALL cover: read addr=0x00F0, rsp_valid 3 cycles after RD_REQ with rsp_data=0x3C, master_ready=1 -> slave_valid for 8 cycles, rd_bus=0,0,1,1,1,1,0,0.
REQ-047 Bench SHALL cover: SPLIT_EN=1, SPLIT_TIMEOUT=8, rsp_valid delayed 20 cycles -> split rises 8 cycles into READ and holds until rsp_valid, then SEND.
REQ-048 Bench SHALL cover: req_ready=0 with 4 write frames -> fifo_count=4, a 5th master_valid held in IDLE with slave_ready=0; req_ready=1 -> entries popped in order and the 5th frame accepted.
REQ-049 Bench SHALL cover: master_valid dropped after 5 address bits -> return to IDLE, fifo_count unchanged, next full frame correct.
REQ-050 Bench SHALL cover: master_ready toggled every other cycle in SEND -> each bit held until acknowledged, 16 cycles total; rstn pulsed mid-SEND -> all outputs 0, FSM in IDLE.
